cd_spi_csr_bridge: RTL

SPI slave (mode 0) that acts as the initiator on the 16-word CSR bus of the CDBUS controller. An external MCU drives the controller over 4-wire SPI.
- First byte of a transaction is a command byte: direction plus register address.
- Following bytes stream 32-bit words to or from the CSR bus; there is no address increment, so bursts on the RX/TX data registers work.
- The `chip_select` output feeds the controller's chip-select input, giving auto page release and pointer reset.

---
 rtl/cd_spi_pkg.sv | 29 ++
 rtl/cd_sync.sv | 32 +++
 rtl/cd_spi_csr_bridge.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cd_spi_pkg
// Description : Shared types and constants for the SPI-to-CSR bridge of the
//               CDBUS controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cd_spi_pkg;

  // Bridge FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  // Direction bit inside the command byte (1 = write)
  localparam int CMD_WR_BIT     = 7;
  localparam int BYTES_PER_WORD = 4;

  // Reorders a little-endian CSR word so a single left shift emits
  // byte0 first, each byte MSB first.
  function automatic logic [31:0] tx_order(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cd_sync.sv
`default_nettype none
// ============================================================================
// Module      : cd_sync
// Description : Single-bit multi-flop synchronizer with configurable depth
//               and reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module cd_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cd_spi_csr_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cd_spi_csr_bridge
// Description : SPI mode-0 slave acting as initiator on the 16-word CSR bus.
//               Byte 0 is a command (bit7 = write, low bits = address), then
//               32-bit little-endian words stream without address increment.
//               Optional macro CD_SPI_MISO_OE_EN adds a spi_miso_oe output
//               that is high only while read data is being shifted out.
// Revision    : 1.0 - initial release
// ============================================================================
module cd_spi_csr_bridge
  import cd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
`ifdef CD_SPI_MISO_OE_EN
  output logic              spi_miso_oe,
`endif
  output logic              chip_select,
  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  input  logic [31:0]       csr_readdata,
  output logic              csr_write,
  output logic [31:0]       csr_writedata
);

  localparam logic [1:0] c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Synchronized SPI pins
  logic w_sck_s;
  logic w_ss_n_s;
  logic w_mosi_s;

  // ss_n resets to "selected" so a reset during a transfer cannot arm the
  // FSM until the master genuinely releases the bus.
  cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk (clk), .rst (reset), .i_d (spi_sck),  .o_q (w_sck_s)
  );
  cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
    .clk (clk), .rst (reset), .i_d (spi_ss_n), .o_q (w_ss_n_s)
  );
  cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (reset), .i_d (spi_mosi), .o_q (w_mosi_s)
  );

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sck_d;
  logic              r_armed;
  logic              r_cs;
  logic [2:0]        r_bit_cnt;
  logic [1:0]        r_byte_cnt;
  logic [6:0]        r_rx;
  logic [23:0]       r_wword;
  logic [31:0]       r_txs;
  logic              r_tx_fresh;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic              w_miso;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic [7:0]        w_rx_next;
  logic              w_bit_last;
  logic              w_word_last;

  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_rx_next   = {r_rx, w_mosi_s};
  assign w_bit_last  = (r_bit_cnt == 3'd7);
  assign w_word_last = w_bit_last && (r_byte_cnt == c_LAST_BYTE);

  // Delayed sck sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_d <= 1'b0;
    end else begin
      r_sck_d <= w_sck_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; deselect always wins
  always_comb begin
    w_state_next = r_state;
    if (w_ss_n_s) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (r_armed) w_state_next = ST_CMD;
        ST_CMD: begin
          if (w_sck_rise && w_bit_last) begin
            w_state_next = w_rx_next[CMD_WR_BIT] ? ST_WR : ST_RD;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // FSM outputs: MISO only driven with data while reading
  always_comb begin
    w_miso = 1'b0;
    if (r_state == ST_RD) begin
      w_miso = r_txs[31];
    end
  end

  // Arm only after ss_n has been seen high since reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_ss_n_s) begin
      r_armed <= 1'b1;
    end
  end

  // Datapath: shift registers, counters and CSR strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs       <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_rx       <= 7'd0;
      r_wword    <= 24'd0;
      r_txs      <= 32'd0;
      r_tx_fresh <= 1'b0;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'd0;
    end else begin
      r_cs    <= ~w_ss_n_s;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      if (w_ss_n_s || (r_state == ST_IDLE)) begin
        // Idle or aborted: drop any partial byte/word
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
        r_rx       <= 7'd0;
        r_wword    <= 24'd0;
        r_txs      <= 32'd0;
        r_tx_fresh <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: begin
            if (w_sck_rise) begin
              r_rx      <= w_rx_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_bit_last) begin
                r_addr <= w_rx_next[ADDR_W-1:0];
                r_read <= ~w_rx_next[CMD_WR_BIT];
              end
            end
          end
          ST_WR: begin
            if (w_sck_rise) begin
              r_rx      <= w_rx_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_bit_last) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                  2'd0:    r_wword[7:0]   <= w_rx_next;
                  2'd1:    r_wword[15:8]  <= w_rx_next;
                  2'd2:    r_wword[23:16] <= w_rx_next;
                  default: r_wword        <= r_wword;
                endcase
              end
              if (w_word_last) begin
                r_wdata <= {w_rx_next, r_wword};
                r_write <= 1'b1;
              end
            end
          end
          ST_RD: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_bit_last) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
              // Prefetch the next word at the end of each word
              if (w_word_last) begin
                r_read <= 1'b1;
              end
            end
            if (w_sck_fall) begin
              // The first fall after a load belongs to the previous bit
              if (r_tx_fresh) begin
                r_tx_fresh <= 1'b0;
              end else begin
                r_txs <= {r_txs[30:0], 1'b0};
              end
            end
          end
          default: r_tx_fresh <= r_tx_fresh;
        endcase
      end
      // Read data is captured in the strobe cycle
      if (r_read) begin
        r_txs      <= tx_order(csr_readdata);
        r_tx_fresh <= 1'b1;
      end
    end
  end

  assign spi_miso      = w_miso;
  assign chip_select   = r_cs;
  assign csr_address   = r_addr;
  assign csr_read      = r_read;
  assign csr_write     = r_write;
  assign csr_writedata = r_wdata;
`ifdef CD_SPI_MISO_OE_EN
  assign spi_miso_oe   = (r_state == ST_RD);
`endif

endmodule
`default_nettype wire
